// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, Rcon, GF(2^8) helpers, key-schedule step and core types.
package aes_pkg;

    localparam int unsigned BLOCK_BITS = 128;
    localparam int unsigned WORD_BITS  = 32;
    localparam int unsigned RND_W      = 4;

    typedef logic [7:0]                 byte_t;
    typedef logic [WORD_BITS-1:0]       word_t;
    typedef logic [0:3][WORD_BITS-1:0]  words_t;
    typedef logic [0:3][7:0]            col_t;
    // [column][row]; bits [127:120] land in column 0, row 0
    typedef logic [0:3][0:3][7:0]       state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } aes_fsm_e;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int unsigned nr(input int unsigned key_bits);
        return (key_bits == 32'd256) ? 32'd14 : 32'd10;
    endfunction

    function automatic byte_t rcon_at(input logic [RND_W-1:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic col_t mix_column(input col_t a);
        col_t b;
        b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
        return b;
    endfunction

    // Next four schedule words from the four words NK back and the latest word.
    function automatic words_t ks_step(input words_t base, input word_t last,
                                       input logic rot, input byte_t rc);
        word_t  t;
        words_t n;
        t    = rot ? (sub_word(rot_word(last)) ^ {rc, 24'h000000}) : sub_word(last);
        n[0] = base[0] ^ t;
        for (int i = 1; i < 4; i++) begin
            n[i] = base[i] ^ n[i-1];
        end
        return n;
    endfunction

endpackage

// File: rtl/aes_encrypt_core_if.sv
// Valid/ready plaintext-in / ciphertext-out bundle for the AES encryptor.
interface aes_encrypt_core_if #(
    parameter int unsigned KEY_BITS = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        plaintext;
    logic [KEY_BITS-1:0] key;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        ciphertext;
    logic                busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round; the final round bypasses MixColumns.
module aes_round
    import aes_pkg::*;
(
    input  state_t state_in,
    input  state_t round_key,
    input  logic   final_round,
    output state_t state_out
);

    state_t sb;
    state_t sr;
    state_t mc;

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[c][r] = SBOX[state_in[c][r]];
            end
        end
        // row r rotates left by r columns
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[c][r] = sb[2'(c + r)][r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[c] = mix_column(sr[c]);
        end
        state_out = (final_round ? sr : mc) ^ round_key;
    end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input logic               clk,
    input logic               rst,
    aes_encrypt_core_if.slave bus
);

    localparam int unsigned NK = KEY_BITS / WORD_BITS;
    localparam int unsigned NR = nr(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_encrypt_core: KEY_BITS must be 128 or 256");
    end

    aes_fsm_e                  state_q, state_d;
    logic [RND_W-1:0]          round_q, round_d;
    logic [0:NK-1][WORD_BITS-1:0] key_win_q, key_win_d, key_win_step;
    state_t                    st_q, st_d, round_out, round_key_st;
    words_t                    round_key;
    logic [BLOCK_BITS-1:0]     ct_q, ct_d;
    logic                      in_ready_q, out_valid_q, busy_q;
    logic                      final_round;

    assign final_round  = (round_q == RND_W'(NR));
    assign round_key_st = round_key;

    if (NK == 4) begin : g_ks128
        // window holds rk[round-1]; each round derives rk[round] from it
        always_comb begin
            round_key    = ks_step(key_win_q, key_win_q[3], 1'b1, rcon_at(round_q - 4'd1));
            key_win_step = round_key;
        end
    end else begin : g_ks256
        words_t new_words;
        // even rounds are odd generation steps (RotWord + Rcon); Rcon index = round/2 - 1
        always_comb begin
            new_words = ks_step(key_win_q[0:3], key_win_q[7], ~round_q[0],
                                rcon_at(4'(round_q[3:1]) - 4'd1));
            if (round_q == 4'd1) begin
                round_key    = key_win_q[4:7];
                key_win_step = key_win_q;
            end else begin
                round_key    = new_words;
                key_win_step = {key_win_q[4:7], new_words};
            end
        end
    end

    aes_round u_round (
        .state_in    (st_q),
        .round_key   (round_key_st),
        .final_round (final_round),
        .state_out   (round_out)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        key_win_d = key_win_q;
        st_d      = st_q;
        ct_d      = ct_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    st_d      = state_t'(bus.plaintext ^ bus.key[KEY_BITS-1 -: BLOCK_BITS]);
                    key_win_d = bus.key;
                    round_d   = 4'd1;
                    state_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                st_d      = round_out;
                key_win_d = key_win_step;
                round_d   = round_q + 4'd1;
                if (final_round) begin
                    ct_d    = round_out;
                    round_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_q     <= '0;
            key_win_q   <= '0;
            st_q        <= '0;
            ct_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            key_win_q   <= key_win_d;
            st_q        <= st_d;
            ct_q        <= ct_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.ciphertext = ct_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed-vector bench for aes_encrypt_core with 128- and 256-bit key instances.
module tb_aes_encrypt_core;

    localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] V3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] V3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp;
    int   n_err;

    always #5 clk = ~clk;

    aes_encrypt_core_if #(.KEY_BITS(128)) bus128 ();
    aes_encrypt_core_if #(.KEY_BITS(256)) bus256 ();

    aes_encrypt_core #(.KEY_BITS(128)) dut128 (
        .clk (clk),
        .rst (rst),
        .bus (bus128.slave)
    );

    aes_encrypt_core #(.KEY_BITS(256)) dut256 (
        .clk (clk),
        .rst (rst),
        .bus (bus256.slave)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit wide, input logic iv, input logic [127:0] pt, input logic [255:0] k);
        if (wide) begin
            bus256.in_valid  = iv;
            bus256.plaintext = pt;
            bus256.key       = k;
        end else begin
            bus128.in_valid  = iv;
            bus128.plaintext = pt;
            bus128.key       = k[255:128];
        end
    endtask

    function automatic logic in_ready_of(input bit wide);
        return wide ? bus256.in_ready : bus128.in_ready;
    endfunction

    function automatic logic out_valid_of(input bit wide);
        return wide ? bus256.out_valid : bus128.out_valid;
    endfunction

    function automatic logic [127:0] ct_of(input bit wide);
        return wide ? bus256.ciphertext : bus128.ciphertext;
    endfunction

    // Hand one block over, scramble the inputs right after acceptance, wait for the result.
    task automatic run_block(input bit wide, input logic [127:0] pt, input logic [255:0] k,
                             output int lat);
        int n;
        n = 0;
        while (!in_ready_of(wide) && n < 40) begin
            tick();
            n++;
        end
        check_eq("accept_ready", 256'(in_ready_of(wide)), 256'(1));
        drive(wide, 1'b1, pt, k);
        tick();
        drive(wide, 1'b0, ~pt, ~k);
        lat = 0;
        while (!out_valid_of(wide) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int gap;
        int seen;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        bus128.out_ready = 1'b1;
        bus256.out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_in_ready",   256'(bus128.in_ready),   256'(1));
        check_eq("rst_out_valid",  256'(bus128.out_valid),  256'(0));
        check_eq("rst_busy",       256'(bus128.busy),       256'(0));
        check_eq("rst_ct",         256'(bus128.ciphertext), 256'(0));
        check_eq("rst_in_ready256", 256'({bus256.in_ready, bus256.busy}), 256'(2'b10));
        rst = 1'b0;

        // FIPS-197 C.1 vector, 128-bit key
        run_block(1'b0, V1_PT, {V1_KEY, 128'h0}, lat);
        check_eq("v1_latency", 256'(lat), 256'(10));
        check_eq("v1_ct",      256'(bus128.ciphertext), 256'(V1_CT));
        check_eq("v1_busy_done", 256'(bus128.busy), 256'(1));
        tick();
        check_eq("v1_consumed", 256'({bus128.in_ready, bus128.out_valid}), 256'(2'b10));

        // FIPS-197 appendix B vector, then a second block held ready behind it
        run_block(1'b0, V2_PT, {V2_KEY, 128'h0}, lat);
        check_eq("v2_latency", 256'(lat), 256'(10));
        check_eq("v2_ct",      256'(bus128.ciphertext), 256'(V2_CT));
        drive(1'b0, 1'b1, V1_PT, {V1_KEY, 128'h0});
        tick();
        check_eq("b2b_idle", 256'({bus128.in_ready, bus128.out_valid}), 256'(2'b10));
        tick();
        drive(1'b0, 1'b0, '0, '0);
        gap = 1;
        while (!bus128.out_valid && gap < 40) begin
            tick();
            gap++;
        end
        check_eq("b2b_gap", 256'(gap), 256'(11));
        check_eq("b2b_ct",  256'(bus128.ciphertext), 256'(V1_CT));
        tick();

        // FIPS-197 C.3 vector, 256-bit key
        run_block(1'b1, V1_PT, V3_KEY, lat);
        check_eq("v3_latency", 256'(lat), 256'(14));
        check_eq("v3_ct",      256'(bus256.ciphertext), 256'(V3_CT));
        tick();
        check_eq("v3_consumed", 256'({bus256.in_ready, bus256.out_valid, bus256.busy}), 256'(3'b100));

        // Backpressure: result must hold while the sink stalls and new inputs wiggle
        bus128.out_ready = 1'b0;
        run_block(1'b0, V2_PT, {V2_KEY, 128'h0}, lat);
        check_eq("bp_latency", 256'(lat), 256'(10));
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'(i % 2), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom, 128'h0});
            tick();
            check_eq("bp_hold", 256'({bus128.out_valid, bus128.in_ready, bus128.busy, bus128.ciphertext}),
                     256'({1'b1, 1'b0, 1'b1, V2_CT}));
        end
        drive(1'b0, 1'b0, '0, '0);
        bus128.out_ready = 1'b1;
        tick();
        check_eq("bp_release", 256'({bus128.in_ready, bus128.out_valid, bus128.busy}), 256'(3'b100));

        // Reset while round 5 is in flight
        drive(1'b0, 1'b1, V2_PT, {V2_KEY, 128'h0});
        tick();
        drive(1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        check_eq("mid_busy", 256'(bus128.busy), 256'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_out_valid", 256'(bus128.out_valid),  256'(0));
        check_eq("mid_rst_ct",        256'(bus128.ciphertext), 256'(0));
        check_eq("mid_rst_busy",      256'(bus128.busy),       256'(0));
        check_eq("mid_rst_in_ready",  256'(bus128.in_ready),   256'(1));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus128.out_valid) seen++;
        end
        check_eq("mid_rst_no_output", 256'(seen), 256'(0));
        run_block(1'b0, V1_PT, {V1_KEY, 128'h0}, lat);
        check_eq("post_rst_latency", 256'(lat), 256'(10));
        check_eq("post_rst_ct",      256'(bus128.ciphertext), 256'(V1_CT));
        tick();

        // Inputs are inverted the cycle after acceptance inside run_block
        run_block(1'b1, V1_PT, V3_KEY, lat);
        check_eq("late_change_ct", 256'(bus256.ciphertext), 256'(V3_CT));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
